boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Sequences the 6-instruction processor through its program life cycle.
- Holds the processor in reset while a program image is streamed into instruction memory over a valid/ready port.
- Releases the processor, monitors its instruction fetches, and reports completion when the fetch address leaves the loaded image, or reports a timeout.
- Sits at top level beside the processor, owning the instruction-memory write port and the processor reset.

Parameters:
- IMEM_DEPTH, 256: maximum program words accepted.
- DATA_W, 16: instruction word width.
- ADDR_W, 16: instruction address width, matching the processor's i_addr.
- RUN_LIMIT, 16'hFFFF: maximum RUN cycles before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  begin load; accepted only in IDLE, DONE or ERR.
- abort  in  1  return to IDLE from any state.
- ld_valid  in  1  program word valid.
- ld_ready  out  1  sequencer accepts a word.
- ld_data  in  DATA_W  program word.
- ld_last  in  1  final word of the image.
- im_wr  out  1  instruction memory write strobe.
- im_addr  out  ADDR_W  instruction memory write address.
- im_w_data  out  DATA_W  instruction memory write data.
- cpu_hold  out  1  1 = processor held in reset; top level maps it to the processor reset.
- cpu_i_rd  in  1  processor fetch strobe.
- cpu_i_addr  in  ADDR_W  processor fetch address.
- busy  out  1  state is LOAD, RELEASE or RUN.
- done  out  1  program completed.
- err  out  1  overflow or timeout.
- prog_len  out  ADDR_W  number of words loaded.
- cycles  out  16  RUN cycle count.

Behaviour:
- Reset values (rst low, asynchronous):
  - state IDLE, cpu_hold 1.
  - ld_ready, im_wr, busy, done, err all 0.
  - im_addr, im_w_data, prog_len, cycles all 0.
- States: IDLE, LOAD, RELEASE, RUN, DONE, ERR. All outputs are registered or decoded from the state register only.
- IDLE: start=1 -> LOAD; clears word counter, cycles, done, err.
- LOAD:
  - ld_ready=1.
  - A transfer occurs when ld_valid and ld_ready are both high.
  - Next cycle after a transfer: im_wr=1, im_addr=word index, im_w_data=ld_data (1-cycle latency). Word index then increments.
  - im_wr is 0 in every cycle without a transfer.
  - Transfer with ld_last=1 -> RELEASE; prog_len = index+1.
  - Transfer at index IMEM_DEPTH-1 with ld_last=0 -> ERR. That word is still written; prog_len = IMEM_DEPTH.
- RELEASE: exactly one cycle, with cpu_hold=1 and ld_ready=0, so the final write lands before the processor starts. Then -> RUN.
- RUN:
  - cpu_hold=0; cycles increments every clock.
  - cpu_i_rd=1 with cpu_i_addr >= prog_len -> DONE (fetch beyond image).
  - cycles == RUN_LIMIT -> ERR. If both conditions occur in the same cycle, DONE wins.
- DONE: done=1, cpu_hold=1; cycles frozen. start -> LOAD (clears done and cycles).
- ERR: err=1, cpu_hold=1. start -> LOAD (clears err).
- abort=1 in any state -> IDLE next cycle:
  - cpu_hold=1, im_wr=0, ld_ready=0.
  - done and err cleared; prog_len and cycles retained.
  - abort has priority over start and over every other transition.
- Ignored inputs:
  - start is ignored in LOAD, RELEASE and RUN.
  - ld_valid is ignored outside LOAD (ld_ready=0).
  - cpu_i_rd is ignored outside RUN.
- cpu_hold transitions 1->0 only on the RELEASE->RUN edge, and 0->1 only on leaving RUN.
- Reset mid-LOAD: the partial image stays in memory. No write is issued after rst falls.
- Widths: word counter is ADDR_W bits; the comparison against prog_len is unsigned.

Decomposition:
- Package boot_pkg holds:
  - the state enum type (IDLE, LOAD, RELEASE, RUN, DONE, ERR);
  - default width constants DATA_W and ADDR_W.
- One sub-module, sat_counter: width-parameterised, with clear, enable and a limit-reached flag. It is used for the RUN cycle count.
- The word counter stays inline.

Test Plan:
- Load 3 words (0x1234, 0x5678, 0x9ABC; last on the third) with ld_valid held high:
  - im_wr pulses at addresses 0, 1, 2 on consecutive cycles with matching data;
  - prog_len=3; one RELEASE cycle, then cpu_hold=0.
- In RUN, drive fetches at 0, 1, 2, then 3:
  - DONE the cycle after the fetch at 3;
  - cpu_hold=1, done=1, cycles equals the elapsed RUN clocks.
- Toggle ld_valid randomly during a 5-word load: exactly 5 im_wr pulses, addresses 0–4, no gaps or duplicates.
- With IMEM_DEPTH=4, stream 4 words with no last: err=1, prog_len=4, cpu_hold stays 1; start then returns to LOAD with err cleared.
- With RUN_LIMIT=10 and no out-of-image fetch: ERR after 10 RUN cycles, cycles=10.
- Mid-RUN cases:
  - assert start and abort together: IDLE next cycle, cpu_hold=1;
  - assert rst low mid-LOAD: all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and default widths for the boot sequencer.
//   state_t : sequencer life-cycle states
//   DATA_W  : default instruction word width
//   ADDR_W  : default instruction address width
package boot_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/boot_sequencer_if.sv
// Bus bundle between the boot sequencer and its neighbours.
//   ld_*    : program image stream (valid/ready, last marks final word)
//   im_*    : instruction memory write port
//   cpu_*   : processor reset hold and fetch monitor
// slave  : the sequencer side
// master : the image source / memory / processor side
interface boot_sequencer_if #(
    parameter int DATA_W = boot_pkg::DATA_W,
    parameter int ADDR_W = boot_pkg::ADDR_W
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              im_wr;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_w_data;
    logic              cpu_hold;
    logic              cpu_i_rd;
    logic [ADDR_W-1:0] cpu_i_addr;

    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_i_rd, cpu_i_addr,
        output ld_ready, im_wr, im_addr, im_w_data, cpu_hold
    );

    modport master (
        output ld_valid, ld_data, ld_last, cpu_i_rd, cpu_i_addr,
        input  ld_ready, im_wr, im_addr, im_w_data, cpu_hold
    );
endinterface

// File: rtl/boot_sequencer_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable; holds once count reaches LIMIT
//   count    : current value
//   reached  : this enabled clock takes count onto LIMIT
module sat_counter #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         reached
);

    logic at_limit;

    assign at_limit = (count == LIMIT);
    // Flag the increment that lands on the limit so the owner can react on
    // the same edge the count becomes LIMIT.
    assign reached  = en && !clr && !at_limit && (count == LIMIT - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                count <= '0;
        else if (clr)            count <= '0;
        else if (en && !at_limit) count <= count + 1'b1;
    end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the processor in reset while an image is streamed
// into instruction memory, releases it, and watches fetches for completion
// (fetch beyond the image) or timeout.
//   clk, rst   : clock, async active-low reset
//   start      : begin a load (IDLE/DONE/ERR only)
//   abort      : return to IDLE from anywhere, highest priority
//   bus        : load stream, imem write port, processor hold/fetch
//   busy       : LOAD, RELEASE or RUN
//   done, err  : completion / overflow-or-timeout status
//   prog_len   : words in the loaded image
//   cycles     : RUN clocks counted
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DATA_W     = boot_pkg::DATA_W,
    parameter int          ADDR_W     = boot_pkg::ADDR_W,
    parameter logic [15:0] RUN_LIMIT  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    boot_sequencer_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] prog_len,
    output logic [15:0]       cycles
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMEM_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] widx;
    logic              xfer, start_ok, run_en, run_hit, fetch_out;
    logic              wr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    assign fetch_out = bus.cpu_i_rd && (bus.cpu_i_addr >= prog_len);
    // abort freezes the count so cycles is retained as of the aborted clock
    assign run_en    = (state_q == RUN) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        xfer     = 1'b0;
        start_ok = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_d  = LOAD;
                        start_ok = 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.ld_valid) begin
                        xfer = 1'b1;
                        if (bus.ld_last)          state_d = RELEASE;
                        else if (widx == LAST_IDX) state_d = ERR;
                    end
                end
                // One cycle still held so the final write lands first
                RELEASE: state_d = RUN;
                RUN: begin
                    if (fetch_out)    state_d = DONE;
                    else if (run_hit) state_d = ERR;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only
    assign bus.ld_ready = (state_q == LOAD);
    assign bus.cpu_hold = (state_q != RUN);
    assign busy         = (state_q == LOAD) || (state_q == RELEASE) || (state_q == RUN);
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);

    // Image write pipeline: one-cycle delayed write of each accepted word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx     <= '0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            prog_len <= '0;
        end else begin
            wr_q <= xfer;
            if (start_ok) widx <= '0;
            if (xfer) begin
                waddr_q <= widx;
                wdata_q <= bus.ld_data;
                widx    <= widx + 1'b1;
                // Overflow word is still written; length then equals depth
                if (bus.ld_last || widx == LAST_IDX) prog_len <= widx + 1'b1;
            end
        end
    end

    assign bus.im_wr     = wr_q;
    assign bus.im_addr   = waddr_q;
    assign bus.im_w_data = wdata_q;

    sat_counter #(.W(16), .LIMIT(RUN_LIMIT)) u_cycles (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (run_en),
        .count   (cycles),
        .reached (run_hit)
    );

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a default-parameter instance for load,
// run-to-completion, random-valid load and abort; a small instance
// (depth 4, run limit 10) for overflow, timeout and async reset.
module tb_boot_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic        a_start, a_abort, a_busy, a_done, a_err;
    logic [15:0] a_prog_len, a_cycles;
    boot_sequencer_if #(.DATA_W(16), .ADDR_W(16)) if_a ();

    boot_sequencer dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .bus(if_a),
        .busy(a_busy), .done(a_done), .err(a_err),
        .prog_len(a_prog_len), .cycles(a_cycles)
    );

    // Instance B: tiny memory and short run limit
    logic        b_start, b_abort, b_busy, b_done, b_err;
    logic [15:0] b_prog_len, b_cycles;
    boot_sequencer_if #(.DATA_W(16), .ADDR_W(16)) if_b ();

    boot_sequencer #(.IMEM_DEPTH(4), .RUN_LIMIT(16'd10)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .bus(if_b),
        .busy(b_busy), .done(b_done), .err(b_err),
        .prog_len(b_prog_len), .cycles(b_cycles)
    );

    // Log of instance A memory writes, sampled away from the active edge
    int          wr_cnt = 0;
    logic [15:0] log_addr [64];
    logic [15:0] log_data [64];
    always @(negedge clk) begin
        if (if_a.im_wr === 1'b1 && wr_cnt < 64) begin
            log_addr[wr_cnt] <= if_a.im_addr;
            log_data[wr_cnt] <= if_a.im_w_data;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;
    int k;

    initial begin
        a_start = 0; a_abort = 0; b_start = 0; b_abort = 0;
        if_a.ld_valid = 0; if_a.ld_data = 0; if_a.ld_last = 0;
        if_a.cpu_i_rd = 0; if_a.cpu_i_addr = 0;
        if_b.ld_valid = 0; if_b.ld_data = 0; if_b.ld_last = 0;
        if_b.cpu_i_rd = 0; if_b.cpu_i_addr = 0;

        // Reset state
        #1 rst = 0;
        #1;
        chk("rst_hold",  {31'd0, if_a.cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, if_a.ld_ready}, 32'd0);
        chk("rst_flags", {29'd0, a_busy, a_done, a_err}, 32'd0);
        chk("rst_imwr",  {31'd0, if_a.im_wr}, 32'd0);
        chk("rst_len",   {16'd0, a_prog_len}, 32'd0);
        chk("rst_cyc",   {16'd0, a_cycles}, 32'd0);
        tick(); tick();
        rst = 1;
        tick();

        // --- Load 3 words into A ---
        a_start = 1;
        tick();
        a_start = 0;
        chk("load_ready", {31'd0, if_a.ld_ready}, 32'd1);
        chk("load_busy",  {31'd0, a_busy}, 32'd1);
        chk("load_nowr",  {31'd0, if_a.im_wr}, 32'd0);
        if_a.ld_valid = 1; if_a.ld_data = 16'h1234;
        tick();
        chk("w0", {15'd0, if_a.im_wr, if_a.im_addr}, {15'd0, 1'b1, 16'd0});
        chk("w0_data", {16'd0, if_a.im_w_data}, 32'h1234);
        if_a.ld_data = 16'h5678;
        tick();
        chk("w1", {15'd0, if_a.im_wr, if_a.im_addr}, {15'd0, 1'b1, 16'd1});
        chk("w1_data", {16'd0, if_a.im_w_data}, 32'h5678);
        if_a.ld_data = 16'h9ABC; if_a.ld_last = 1;
        tick();
        chk("w2", {15'd0, if_a.im_wr, if_a.im_addr}, {15'd0, 1'b1, 16'd2});
        chk("w2_data", {16'd0, if_a.im_w_data}, 32'h9ABC);
        chk("rel_len", {16'd0, a_prog_len}, 32'd3);
        chk("rel_hold_ready", {30'd0, if_a.cpu_hold, if_a.ld_ready}, 32'b10);
        if_a.ld_valid = 0; if_a.ld_last = 0;
        tick();
        chk("run_hold", {31'd0, if_a.cpu_hold}, 32'd0);
        chk("run_nowr", {31'd0, if_a.im_wr}, 32'd0);
        chk("run_cyc0", {16'd0, a_cycles}, 32'd0);

        // Fetches inside the image, then one past it
        if_a.cpu_i_rd = 1; if_a.cpu_i_addr = 0;
        tick();
        if_a.cpu_i_addr = 1;
        tick();
        if_a.cpu_i_addr = 2;
        tick();
        chk("run_still", {30'd0, a_busy, if_a.cpu_hold}, 32'b10);
        if_a.cpu_i_addr = 3;
        tick();
        if_a.cpu_i_rd = 0;
        chk("done_flag", {30'd0, a_done, a_busy}, 32'b10);
        chk("done_hold", {31'd0, if_a.cpu_hold}, 32'd1);
        chk("done_cyc",  {16'd0, a_cycles}, 32'd4);
        tick();
        chk("done_frozen", {16'd0, a_cycles}, 32'd4);

        // --- Restart A, 5-word load with random ld_valid ---
        a_start = 1;
        tick();
        a_start = 0;
        chk("restart_clr", {30'd0, a_done, a_err}, 32'd0);
        chk("restart_cyc", {16'd0, a_cycles}, 32'd0);
        base = wr_cnt;
        k = 0;
        for (int n = 0; n < 200 && k < 5; n++) begin
            if_a.ld_valid = 1'($urandom_range(0, 1));
            if_a.ld_data  = 16'hA000 + 16'(k);
            if_a.ld_last  = (k == 4);
            tick();
            if (if_a.ld_valid) k++;
        end
        chk("rand_sent", k, 5);
        if_a.ld_valid = 0; if_a.ld_last = 0;
        tick();
        chk("rand_count", wr_cnt - base, 5);
        for (int i = 0; i < 5; i++) begin
            chk("rand_addr", {16'd0, log_addr[(base + i) % 64]}, i);
            chk("rand_data", {16'd0, log_data[(base + i) % 64]}, 32'hA000 + i);
        end
        chk("rand_len",  {16'd0, a_prog_len}, 32'd5);
        chk("rand_run",  {31'd0, if_a.cpu_hold}, 32'd0);

        // start + abort together mid-RUN: abort wins
        a_start = 1; a_abort = 1;
        tick();
        a_start = 0; a_abort = 0;
        chk("abort_idle",  {29'd0, a_busy, a_done, a_err}, 32'd0);
        chk("abort_hold",  {30'd0, if_a.cpu_hold, if_a.ld_ready}, 32'b10);
        chk("abort_len",   {16'd0, a_prog_len}, 32'd5);
        tick();
        chk("abort_stays", {31'd0, a_busy}, 32'd0);

        // --- B: overflow at depth 4 ---
        b_start = 1;
        tick();
        b_start = 0;
        if_b.ld_valid = 1;
        for (int i = 0; i < 4; i++) begin
            if_b.ld_data = 16'hB000 + 16'(i);
            tick();
            if (i < 3) chk("ovf_hold", {31'd0, if_b.cpu_hold}, 32'd1);
        end
        if_b.ld_valid = 0;
        chk("ovf_err",  {30'd0, b_err, b_busy}, 32'b10);
        chk("ovf_len",  {16'd0, b_prog_len}, 32'd4);
        chk("ovf_last", {15'd0, if_b.im_wr, if_b.im_addr}, {15'd0, 1'b1, 16'd3});
        chk("ovf_hold", {31'd0, if_b.cpu_hold}, 32'd1);
        tick();
        chk("ovf_keep", {30'd0, b_err, if_b.im_wr}, 32'b10);
        b_start = 1;
        tick();
        b_start = 0;
        chk("ovf_restart", {30'd0, b_err, if_b.ld_ready}, 32'b01);

        // --- B: timeout with no out-of-image fetch ---
        if_b.ld_valid = 1; if_b.ld_data = 16'hC000;
        tick();
        if_b.ld_data = 16'hC001; if_b.ld_last = 1;
        tick();
        if_b.ld_valid = 0; if_b.ld_last = 0;
        chk("to_len", {16'd0, b_prog_len}, 32'd2);
        tick();
        chk("to_run", {31'd0, if_b.cpu_hold}, 32'd0);
        if_b.cpu_i_rd = 1; if_b.cpu_i_addr = 1;
        repeat (9) tick();
        chk("to_before", {30'd0, b_busy, b_err}, 32'b10);
        chk("to_cyc9",   {16'd0, b_cycles}, 32'd9);
        tick();
        if_b.cpu_i_rd = 0;
        chk("to_err",  {30'd0, b_err, if_b.cpu_hold}, 32'b11);
        chk("to_cyc",  {16'd0, b_cycles}, 32'd10);

        // --- B: asynchronous reset mid-LOAD ---
        b_start = 1;
        tick();
        b_start = 0;
        if_b.ld_valid = 1; if_b.ld_data = 16'hD000;
        tick();
        chk("pre_rst_wr", {31'd0, if_b.im_wr}, 32'd1);
        #2 rst = 0;
        #1;
        chk("arst_wr",    {31'd0, if_b.im_wr}, 32'd0);
        chk("arst_ready", {30'd0, if_b.ld_ready, if_b.cpu_hold}, 32'b01);
        chk("arst_flags", {29'd0, b_busy, b_done, b_err}, 32'd0);
        chk("arst_bus",   {if_b.im_addr, if_b.im_w_data}, 32'd0);
        chk("arst_cnt",   {b_prog_len, b_cycles}, 32'd0);
        tick();
        chk("arst_nowr",  {31'd0, if_b.im_wr}, 32'd0);
        if_b.ld_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
